bus_arbiter: RTL and testbench

Arbiter that shares the single memory bus between up to N masters (processor ports and the DMA controller) using the codebase's active-low request/grant pair. It sits between the masters and the bus multiplexer in `top`. It registers one grant at a time and drives an owner index for the address/data/rw muxes. It supports round-robin or fixed priority, and a bounded tenure that preempts a long-holding master when others are waiting.

---
 rtl/bus_arbiter_pkg.sv | 35 +++
 rtl/bus_arbiter_pick.sv | 54 +++++
 rtl/bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_bus_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: constants and types shared by the bus arbiter and its
// winner-selection helper.
//   ENABLE_/DISABLE_ : levels of the active-low request/grant pair
//   ARB_RR/ARB_FIXED : values of the arbitration mode input
//   arb_state_e      : arbiter FSM state encoding
//   wrap_inc()       : modulo-n increment used for the round-robin pointer
package bus_arbiter_pkg;

  // Active-low request/grant levels.
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // Arbitration modes.
  localparam logic ARB_RR    = 1'b0;
  localparam logic ARB_FIXED = 1'b1;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_TURN  = 2'd2
  } arb_state_e;

  // (idx + 1) mod n, for idx < n.
  function automatic int unsigned wrap_inc(input int unsigned idx,
                                           input int unsigned n);
    int unsigned nxt;
    nxt = idx + 32'd1;
    if (nxt >= n) begin
      nxt = 32'd0;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bus_arbiter_pick.sv
// arb_pick: combinational rotate-and-find-first winner selection.
//   req      in  N  : request vector, active-high
//   start    in  IW : first index examined in round-robin mode
//   mode     in  1  : ARB_RR scans upward from start (wrapping),
//                     ARB_FIXED scans upward from 0 (lowest index wins)
//   winner_c out IW : selected index (0 when no hit)
//   hit_c    out 1  : at least one request present
module arb_pick
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  input  logic          mode,
  output logic [IW-1:0] winner_c,
  output logic          hit_c
);

  logic [2*N-1:0] dbl_c;
  logic [N-1:0]   rot_c;
  int unsigned    base_c;
  int unsigned    off_c;
  int unsigned    sum_c;

  // Rotate the request vector so the scan start sits at bit 0, then take
  // the first set bit and map its offset back to an absolute index.
  always_comb begin
    winner_c = '0;
    hit_c    = 1'b0;
    off_c    = 32'd0;
    base_c   = (mode == ARB_FIXED) ? 32'd0 : 32'(start);
    if (base_c >= N) begin
      base_c = 32'd0;
    end
    dbl_c = {req, req} >> base_c;
    rot_c = dbl_c[N-1:0];
    for (int k = 0; k < N; k++) begin
      if (!hit_c && rot_c[k]) begin
        hit_c = 1'b1;
        off_c = 32'(k);
      end
    end
    sum_c = base_c + off_c;
    if (sum_c >= N) begin
      sum_c = sum_c - N;
    end
    if (hit_c) begin
      winner_c = IW'(sum_c);
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares the memory bus between N masters using active-low
// request/grant pairs. One registered grant at a time, round-robin or
// fixed-priority selection, and optional tenure-based preemption.
//   clk         in  1  : rising-edge clock
//   reset       in  1  : synchronous active-high reset
//   breq_       in  N  : per-master request, active-low
//   mode        in  1  : ARB_RR (0) or ARB_FIXED (1), sampled at arbitration
//   bgrt_       out N  : per-master grant, active-low, one-cold at most
//   owner       out IW : current grantee index (bus mux select)
//   owner_valid out 1  : a grant is active
//   preempt     out 1  : one-cycle pulse after a tenure-expiry revocation
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned IW       = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  breq_,
  input  logic          mode,
  output logic [N-1:0]  bgrt_,
  output logic [IW-1:0] owner,
  output logic          owner_valid,
  output logic          preempt
);

  // Tenure counter only needs to reach MAX_HOLD.
  localparam int unsigned HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  arb_state_e    state, state_n;
  logic [HW-1:0] hold_cnt, hold_cnt_n;
  logic [IW-1:0] rr_ptr, rr_ptr_n;
  logic [N-1:0]  bgrt_n;
  logic [IW-1:0] owner_n;
  logic          owner_valid_n;
  logic          preempt_n;

  logic [N-1:0]  req_c;
  logic [N-1:0]  owner_mask_c;
  logic          owner_req_c;
  logic          others_req_c;
  logic          expired_c;
  logic          at_max_c;
  logic [IW-1:0] win_c;
  logic          hit_c;

  // Request decode relative to the current owner.
  always_comb begin
    req_c        = ~breq_;
    owner_mask_c = N'(1) << owner;
    owner_req_c  = |(req_c & owner_mask_c);
    others_req_c = |(req_c & ~owner_mask_c);
    at_max_c     = (hold_cnt == HW'(MAX_HOLD));
    expired_c    = (MAX_HOLD != 0) && at_max_c;
  end

  arb_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req      (req_c),
    .start    (rr_ptr),
    .mode     (mode),
    .winner_c (win_c),
    .hit_c    (hit_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_n       = state;
    hold_cnt_n    = hold_cnt;
    rr_ptr_n      = rr_ptr;
    bgrt_n        = bgrt_;
    owner_n       = owner;
    owner_valid_n = owner_valid;
    preempt_n     = 1'b0;

    case (state)
      // IDLE and the dead TURN cycle arbitrate identically.
      ARB_IDLE, ARB_TURN: begin
        state_n       = ARB_IDLE;
        bgrt_n        = {N{DISABLE_}};
        owner_valid_n = 1'b0;
        if (hit_c) begin
          state_n       = ARB_GRANT;
          bgrt_n        = ~(N'(1) << win_c);
          owner_n       = win_c;
          owner_valid_n = 1'b1;
          rr_ptr_n      = IW'(wrap_inc(32'(win_c), N));
          hold_cnt_n    = '0;
        end
      end

      // Release wins over expiry when both happen at the same edge.
      ARB_GRANT: begin
        if (!owner_req_c) begin
          state_n       = ARB_TURN;
          bgrt_n        = {N{DISABLE_}};
          owner_valid_n = 1'b0;
        end else if (expired_c && others_req_c) begin
          state_n       = ARB_TURN;
          bgrt_n        = {N{DISABLE_}};
          owner_valid_n = 1'b0;
          preempt_n     = 1'b1;
        end else if (!at_max_c) begin
          hold_cnt_n = hold_cnt + HW'(1);
        end
      end

      default: begin
        state_n       = ARB_IDLE;
        bgrt_n        = {N{DISABLE_}};
        owner_valid_n = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ARB_IDLE;
      hold_cnt    <= '0;
      rr_ptr      <= '0;
      bgrt_       <= {N{DISABLE_}};
      owner       <= '0;
      owner_valid <= 1'b0;
      preempt     <= 1'b0;
    end else begin
      state       <= state_n;
      hold_cnt    <= hold_cnt_n;
      rr_ptr      <= rr_ptr_n;
      bgrt_       <= bgrt_n;
      owner       <= owner_n;
      owner_valid <= owner_valid_n;
      preempt     <= preempt_n;
    end
  end

  // At most one grant, and owner_valid tracks the grant vector.
  a_one_cold: assert property (@(posedge clk) disable iff (reset)
    $onehot0(~bgrt_));
  a_valid_match: assert property (@(posedge clk) disable iff (reset)
    owner_valid == !(&bgrt_));

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios plus randomized traffic for
// bus_arbiter (N=4, MAX_HOLD=4), checked every cycle against a
// behavioural model that tracks only who owns the bus.
module tb_bus_arbiter;

  localparam int N  = 4;
  localparam int MH = 4;

  logic         clk;
  logic         reset;
  logic [N-1:0] breq_;
  logic         mode;
  logic [N-1:0] bgrt_;
  logic [1:0]   owner;
  logic         owner_valid;
  logic         preempt;

  int errors = 0;
  int checks = 0;

  // Model: current owner (-1 = none), RR start, tenure count, preempt pulse.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_ten   = 0;
  bit m_pre   = 1'b0;

  bus_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
    .clk         (clk),
    .reset       (reset),
    .breq_       (breq_),
    .mode        (mode),
    .bgrt_       (bgrt_),
    .owner       (owner),
    .owner_valid (owner_valid),
    .preempt     (preempt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] req, input int start,
                              input logic fixed);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = fixed ? k : (start + k) % N;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  // Advance the model by the inputs sampled at this edge.
  task automatic model_edge();
    logic [N-1:0] req;
    int others;
    int w;
    req = ~breq_;
    if (reset) begin
      m_owner = -1; m_ptr = 0; m_ten = 0; m_pre = 1'b0;
    end else begin
      m_pre = 1'b0;
      if (m_owner >= 0) begin
        others = 0;
        for (int i = 0; i < N; i++)
          if (i != m_owner && req[i]) others++;
        if (!req[m_owner]) begin
          m_owner = -1;
        end else if (MH != 0 && m_ten == MH && others > 0) begin
          m_owner = -1;
          m_pre   = 1'b1;
        end else if (m_ten < MH) begin
          m_ten++;
        end
      end else begin
        w = pick(req, m_ptr, mode);
        if (w >= 0) begin
          m_owner = w;
          m_ptr   = (w + 1) % N;
          m_ten   = 0;
        end
      end
    end
  endtask

  // One clock: update the model at the edge, compare outputs 1 ns later.
  task automatic step();
    logic [N-1:0] exp_g;
    @(posedge clk);
    model_edge();
    #1;
    exp_g = '1;
    if (m_owner >= 0) exp_g[m_owner] = 1'b0;
    check("bgrt_", 32'(bgrt_), 32'(exp_g));
    check("owner_valid", 32'(owner_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
    check("preempt", 32'(preempt), 32'(m_pre));
    if (m_owner >= 0) check("owner", 32'(owner), 32'(m_owner));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int cnt;
    int dead;
    int order[$];
    int gaps[$];
    int gcnt[N];
    bit prev_v;
    int exp_order[5];

    reset = 1'b1;
    breq_ = '1;
    mode  = 1'b0;

    // Reset held for 3 cycles with every master requesting.
    breq_ = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_bgrt", 32'(bgrt_), 32'hF);
      check("rst_valid", 32'(owner_valid), 32'd0);
    end
    reset = 1'b0;
    step();
    check("rst_first_grant", 32'(bgrt_), 32'b1110);

    // Single master: 5 requesting edges give 5 granted cycles, then TURN.
    breq_ = 4'b1111;
    do_reset();
    breq_ = 4'b1110;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bgrt_[0] == 1'b0 && owner == 2'd0) cnt++;
    end
    breq_ = 4'b1111;
    step();
    check("single_cycles", 32'(cnt), 32'd5);
    check("single_turn", 32'(bgrt_), 32'hF);
    step();
    check("single_idle", 32'(bgrt_), 32'hF);

    // Round-robin: all request, each releases after 3 granted cycles.
    mode  = 1'b0;
    breq_ = 4'b0000;
    do_reset();
    for (int i = 0; i < N; i++) gcnt[i] = 0;
    prev_v = 1'b0;
    dead   = 0;
    for (int c = 0; c < 60 && order.size() < 5; c++) begin
      step();
      if (owner_valid) begin
        if (!prev_v) begin
          if (order.size() > 0) gaps.push_back(dead);
          order.push_back(int'(owner));
          dead = 0;
        end
      end else begin
        dead++;
      end
      prev_v = owner_valid;
      for (int i = 0; i < N; i++) begin
        if (bgrt_[i] == 1'b0) gcnt[i]++;
        breq_[i] = (gcnt[i] == 3);
        if (gcnt[i] == 3) gcnt[i] = 0;
      end
    end
    check("rr_grants", 32'(order.size()), 32'd5);
    exp_order = '{0, 1, 2, 3, 0};
    for (int k = 0; k < order.size() && k < 5; k++)
      check("rr_order", 32'(order[k]), 32'(exp_order[k]));
    foreach (gaps[k]) check("rr_gap", 32'(gaps[k]), 32'd1);

    // Fixed priority: 2 owns, 3 and 1 wait; 1 then 3 follow.
    mode  = 1'b1;
    breq_ = 4'b1111;
    do_reset();
    breq_ = 4'b1011;
    step();
    check("fix_owner2", 32'(owner), 32'd2);
    breq_ = 4'b0001;
    step();
    breq_ = 4'b0101;
    step();
    step();
    check("fix_owner1", 32'(owner), 32'd1);
    breq_ = 4'b0111;
    step();
    step();
    check("fix_owner3", 32'(owner), 32'd3);
    check("fix_valid3", 32'(owner_valid), 32'd1);

    // Preemption: DMA holds, master 0 joins; revoked after MH+1 cycles.
    mode  = 1'b0;
    breq_ = 4'b1111;
    do_reset();
    breq_ = 4'b0111;
    step();
    cnt = 0;
    for (int c = 0; c < 20 && bgrt_[3] == 1'b0; c++) begin
      cnt++;
      if (cnt == 2) breq_ = 4'b0110;
      step();
    end
    check("pre_tenure", 32'(cnt), 32'(MH + 1));
    check("pre_pulse", 32'(preempt), 32'd1);
    step();
    check("pre_pulse_end", 32'(preempt), 32'd0);
    check("pre_next_owner", 32'(owner), 32'd0);
    check("pre_next_valid", 32'(owner_valid), 32'd1);

    // Reset mid-grant; RR restarts at index 0.
    breq_ = 4'b1011;
    do_reset();
    step();
    check("mid_owner2", 32'(owner), 32'd2);
    step();
    breq_ = 4'b1010;
    reset = 1'b1;
    step();
    check("mid_rst_bgrt", 32'(bgrt_), 32'hF);
    check("mid_rst_owner", 32'(owner), 32'd0);
    reset = 1'b0;
    step();
    check("mid_after_owner", 32'(owner), 32'd0);

    // Randomized traffic with occasional mode flips and resets.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(3) == 0) breq_[i] = ~breq_[i];
      if ($urandom_range(39) == 0) mode = ~mode;
      reset = ($urandom_range(149) == 0);
      step();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
